// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions: sequencer states, flag/abort patterns and frame limits.
package hdlc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_FLAG,
    DATA,
    END_FLAG,
    ABORT
  } hdlc_state_e;

  localparam logic [7:0]  HDLC_FLAG       = 8'h7E;
  localparam logic [7:0]  HDLC_ABORT      = 8'hFE;
  localparam int unsigned MAX_FRAME_BYTES = 126;

  function automatic logic frame_size_ok(input logic [7:0] size, input int unsigned max_bytes);
    return (size != 8'd0) && ({24'd0, size} <= max_bytes);
  endfunction

endpackage

// File: rtl/hdlc_zero_insert.sv
// Ones-run tracker for HDLC bit stuffing: asks for a zero after five consecutive data ones.
module hdlc_zero_insert (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic bit_i,
  input  logic valid_i,
  input  logic clear_i,
  output logic stall_o,
  output logic insert_o
);

  localparam logic [2:0] RUN_LIMIT = 3'd5;

  logic [2:0] ones_q, ones_d;
  logic [2:0] base;

  assign insert_o = (ones_q == RUN_LIMIT);
  assign stall_o  = insert_o & valid_i;

  // clear only resets the base, so the first bit launched on entry still counts
  always_comb begin
    base   = clear_i ? '0 : ones_q;
    ones_d = base;
    if (stall_o) begin
      ones_d = '0;
    end else if (valid_i) begin
      ones_d = bit_i ? (base + 3'd1) : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/hdlc_tx_sequencer.sv
// HDLC transmit sequencer: idle ones, start flag, LSB-first stuffed payload, end flag, abort.
module hdlc_tx_sequencer
  import hdlc_pkg::*;
#(
  parameter int unsigned MAX_BYTES = MAX_FRAME_BYTES
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_ValidFrame,
  input  logic       Tx_AbortFrame,
  input  logic [7:0] Tx_FrameSize,
  input  logic [7:0] Tx_Data,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans
);

  hdlc_state_e state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  size_q, size_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;

  logic last_bit, last_byte, abort_req, data_bit;
  logic zi_valid, zi_clear, zi_stall, zi_insert;

  assign last_bit  = (bit_cnt_q == 3'd7);
  assign last_byte = (byte_cnt_q == (size_q - 8'd1));
  assign abort_req = Tx_AbortFrame & (state_q inside {START_FLAG, DATA, END_FLAG});

  // Candidate bit for the next data-phase launch (first bit of a byte, next bit, or end flag).
  always_comb begin
    data_bit = shreg_q[0];
    if (state_q == START_FLAG) begin
      data_bit = Tx_Data[0];
    end else if (last_bit) begin
      data_bit = last_byte ? HDLC_FLAG[0] : Tx_Data[0];
    end
  end

  assign zi_valid = ~abort_req & (((state_q == START_FLAG) & last_bit) | (state_q == DATA));
  assign zi_clear = (state_q != DATA);

  hdlc_zero_insert u_zero_insert (
    .clk_i    (Clk),
    .rst_ni   (Rst),
    .bit_i    (data_bit),
    .valid_i  (zi_valid),
    .clear_i  (zi_clear),
    .stall_o  (zi_stall),
    .insert_o (zi_insert)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    size_d     = size_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    rd_d       = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    if (abort_req) begin
      state_d   = ABORT;
      bit_cnt_d = '0;
      tx_d      = HDLC_ABORT[0];
      shreg_d   = HDLC_ABORT >> 1;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_d = 1'b1;
          if (Tx_ValidFrame && !Tx_AbortFrame && frame_size_ok(Tx_FrameSize, MAX_BYTES)) begin
            state_d    = START_FLAG;
            size_d     = Tx_FrameSize;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            tx_d       = HDLC_FLAG[0];
            shreg_d    = HDLC_FLAG >> 1;
          end
        end

        START_FLAG: begin
          if (last_bit) begin
            state_d    = DATA;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            tx_d       = data_bit;
            shreg_d    = Tx_Data >> 1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            rd_d      = (bit_cnt_q == 3'd5);
          end
        end

        DATA: begin
          tx_d = zi_insert ? 1'b0 : data_bit;
          if (!zi_stall) begin
            if (!last_bit) begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shreg_d   = shreg_q >> 1;
              rd_d      = (bit_cnt_q == 3'd5) && !last_byte;
            end else if (!last_byte) begin
              bit_cnt_d  = '0;
              byte_cnt_d = byte_cnt_q + 8'd1;
              shreg_d    = Tx_Data >> 1;
            end else begin
              state_d   = END_FLAG;
              bit_cnt_d = '0;
              shreg_d   = HDLC_FLAG >> 1;
            end
          end
        end

        END_FLAG: begin
          if (last_bit) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end

        ABORT: begin
          if (last_bit) begin
            state_d   = IDLE;
            tx_d      = 1'b1;
            aborted_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end

        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      size_q     <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      size_q     <= size_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign Tx              = tx_q;
  assign Tx_RdBuff       = rd_q;
  assign Tx_Busy         = busy_q;
  assign Tx_Done         = done_q;
  assign Tx_AbortedTrans = aborted_q;

endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// Bench for hdlc_tx_sequencer: directed table, hand-written corner sequences, random frames vs a bit-stream model.
module tb_hdlc_tx_sequencer;

  logic       Clk;
  logic       Rst;
  logic       Tx_ValidFrame;
  logic       Tx_AbortFrame;
  logic [7:0] Tx_FrameSize;
  logic [7:0] Tx_Data;
  logic       Tx_RdBuff;
  logic       Tx;
  logic       Tx_Busy;
  logic       Tx_Done;
  logic       Tx_AbortedTrans;

  hdlc_tx_sequencer #(.MAX_BYTES(126)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Tx_ValidFrame   (Tx_ValidFrame),
    .Tx_AbortFrame   (Tx_AbortFrame),
    .Tx_FrameSize    (Tx_FrameSize),
    .Tx_Data         (Tx_Data),
    .Tx_RdBuff       (Tx_RdBuff),
    .Tx              (Tx),
    .Tx_Busy         (Tx_Busy),
    .Tx_Done         (Tx_Done),
    .Tx_AbortedTrans (Tx_AbortedTrans)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    int             n;
    logic [7:0][7:0] data;
    int             abort_at;
    int             exp_len;
  } vec_t;

  int   checks;
  int   errors;
  logic exp_line[$];
  int   rd_pos[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input int a, input int len);
    vec_t v;
    v.n        = n;
    v.data     = '0;
    v.data[0]  = b0;
    v.data[1]  = b1;
    v.data[2]  = b2;
    v.abort_at = a;
    v.exp_len  = len;
    return v;
  endfunction

  // Expected line contents per cycle after the accepting cycle, and the cycles carrying Tx_RdBuff.
  task automatic build_model(input vec_t v);
    logic [7:0] flag;
    int ones;
    logic b;
    flag = 8'h7E;
    exp_line.delete();
    rd_pos.delete();
    for (int i = 0; i < 8; i++) exp_line.push_back(flag[i]);
    rd_pos.push_back(6);
    ones = 0;
    for (int k = 0; k < v.n; k++) begin
      for (int j = 0; j < 8; j++) begin
        b = v.data[k][j];
        if (j == 6 && k < v.n - 1) rd_pos.push_back(exp_line.size());
        exp_line.push_back(b);
        ones = b ? ones + 1 : 0;
        if (ones == 5) begin
          exp_line.push_back(1'b0);
          ones = 0;
        end
      end
    end
    for (int i = 0; i < 8; i++) exp_line.push_back(flag[i]);
    if (v.abort_at >= 0) begin
      while (exp_line.size() > v.abort_at + 1) void'(exp_line.pop_back());
      while (rd_pos.size() > 0 && rd_pos[rd_pos.size() - 1] > v.abort_at) void'(rd_pos.pop_back());
      exp_line.push_back(1'b0);
      for (int i = 0; i < 7; i++) exp_line.push_back(1'b1);
    end
  endtask

  task automatic run_frame(input vec_t v, input bit started, input bit chain, input string tag);
    int lx, k, seen_end, last_i;
    int e_tx, e_busy, e_rd, e_done, e_ab;
    logic prev_rd, exp_tx, exp_rd, is_abort;
    build_model(v);
    lx       = exp_line.size();
    is_abort = (v.abort_at >= 0);
    if (!started) begin
      Tx_ValidFrame = 1'b1;
      Tx_FrameSize  = v.n[7:0];
      @(posedge Clk); #1;
      Tx_ValidFrame = 1'b0;
    end
    k = 0; prev_rd = 1'b0; seen_end = -1;
    e_tx = 0; e_busy = 0; e_rd = 0; e_done = 0; e_ab = 0;
    last_i = chain ? lx : lx + 1;
    for (int i = 0; i <= last_i; i++) begin
      if (prev_rd && k < 8) begin
        Tx_Data = v.data[k];
        k++;
      end
      Tx_AbortFrame = (i == v.abort_at);
      if (chain && i == lx) begin
        Tx_ValidFrame = 1'b1;
        Tx_FrameSize  = v.n[7:0];
      end
      exp_tx = (i < lx) ? exp_line[i] : 1'b1;
      exp_rd = 1'b0;
      foreach (rd_pos[j]) if (rd_pos[j] == i) exp_rd = 1'b1;
      if (Tx !== exp_tx) e_tx++;
      if (Tx_Busy !== (i < lx)) e_busy++;
      if (Tx_RdBuff !== exp_rd) e_rd++;
      if (Tx_Done !== (i == lx && !is_abort)) e_done++;
      if (Tx_AbortedTrans !== (i == lx && is_abort)) e_ab++;
      if (seen_end < 0 && (Tx_Done === 1'b1 || Tx_AbortedTrans === 1'b1)) seen_end = i;
      prev_rd = Tx_RdBuff;
      @(posedge Clk); #1;
    end
    Tx_AbortFrame = 1'b0;
    Tx_ValidFrame = 1'b0;
    chk({tag, "_txline"}, e_tx, 0);
    chk({tag, "_busy"}, e_busy, 0);
    chk({tag, "_rdbuff"}, e_rd, 0);
    chk({tag, "_done"}, e_done, 0);
    chk({tag, "_aborted"}, e_ab, 0);
    if (v.exp_len > 0) chk({tag, "_len"}, seen_end, v.exp_len);
    else               chk({tag, "_len"}, seen_end, lx);
  endtask

  task automatic idle_check(input logic [7:0] size, input logic with_abort, input string tag);
    int e_tx, e_busy, e_pulse;
    e_tx = 0; e_busy = 0; e_pulse = 0;
    Tx_ValidFrame = 1'b1;
    Tx_AbortFrame = with_abort;
    Tx_FrameSize  = size;
    @(posedge Clk); #1;
    Tx_ValidFrame = 1'b0;
    Tx_AbortFrame = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (Tx !== 1'b1) e_tx++;
      if (Tx_Busy !== 1'b0) e_busy++;
      if ({Tx_RdBuff, Tx_Done, Tx_AbortedTrans} !== 3'b000) e_pulse++;
      @(posedge Clk); #1;
    end
    chk({tag, "_tx"}, e_tx, 0);
    chk({tag, "_busy"}, e_busy, 0);
    chk({tag, "_pulses"}, e_pulse, 0);
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    checks = 0;
    errors = 0;
    Rst = 1'b0;
    Tx_ValidFrame = 1'b0;
    Tx_AbortFrame = 1'b0;
    Tx_FrameSize  = 8'd0;
    Tx_Data       = 8'd0;

    tbl[0] = mk(1, 8'h00, 8'h00, 8'h00, -1, 24);
    tbl[1] = mk(2, 8'hFF, 8'hFF, 8'h00, -1, 35);
    tbl[2] = mk(3, 8'hA5, 8'h3C, 8'hF0, 19, 28);
    tbl[3] = mk(1, 8'h7E, 8'h00, 8'h00, -1, 25);
    tbl[4] = mk(2, 8'h1F, 8'hF8, 8'h00, -1, 34);
    tbl[5] = mk(1, 8'h00, 8'h00, 8'h00, 23, 32);
    tbl[6] = mk(2, 8'h55, 8'hAA, 8'h00, 2, 11);

    repeat (2) @(posedge Clk); #1;
    chk("rst_outputs", {Tx, Tx_Busy, Tx_RdBuff, Tx_Done, Tx_AbortedTrans}, 5'b10000);
    Rst = 1'b1;
    repeat (2) @(posedge Clk); #1;
    chk("idle_after_rst", {Tx, Tx_Busy, Tx_RdBuff, Tx_Done, Tx_AbortedTrans}, 5'b10000);

    foreach (tbl[i]) run_frame(tbl[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

    idle_check(8'd0, 1'b0, "size0");
    idle_check(8'd127, 1'b0, "size127");
    idle_check(8'd1, 1'b1, "valid_abort");

    // Back-to-back frames: the second request lands in the Tx_Done cycle.
    run_frame(mk(1, 8'h3C, 8'h00, 8'h00, -1, 24), 1'b0, 1'b1, "b2b_first");
    run_frame(mk(1, 8'hC3, 8'h00, 8'h00, -1, 24), 1'b1, 1'b0, "b2b_second");

    // Reset in the middle of DATA, while an inserted zero is on the line.
    Tx_Data       = 8'hFF;
    Tx_ValidFrame = 1'b1;
    Tx_FrameSize  = 8'd2;
    @(posedge Clk); #1;
    Tx_ValidFrame = 1'b0;
    repeat (13) @(posedge Clk); #1;
    chk("mid_pre_tx", {Tx, Tx_Busy}, 2'b01);
    #3 Rst = 1'b0;
    #1 chk("mid_rst_outputs", {Tx, Tx_Busy, Tx_RdBuff, Tx_Done, Tx_AbortedTrans}, 5'b10000);
    @(posedge Clk); @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    run_frame(mk(1, 8'h81, 8'h00, 8'h00, -1, 24), 1'b0, 1'b0, "post_rst");

    for (int f = 0; f < 20; f++) begin
      rv = mk(int'($urandom_range(1, 5)), 8'h00, 8'h00, 8'h00, -1, -1);
      for (int k = 0; k < 8; k++)
        rv.data[k] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      if ($urandom_range(0, 3) == 0) begin
        build_model(rv);
        rv.abort_at = int'($urandom_range(0, exp_line.size() - 1));
      end
      run_frame(rv, 1'b0, 1'b0, $sformatf("rand%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdlc_tx_sequencer.md
# hdlc_tx_sequencer

Transmit-side frame sequencer for the HDLC controller. It takes a frame of buffered bytes and drives the serial Tx line: idle ones, start flag, LSB-first payload with zero insertion, end flag. It also emits the abort pattern on request. It sits between the Tx byte buffer and the Tx pin and produces the Tx_AbortedTrans status consumed by the register interface.

## Interface
- MAX_BYTES, 126: largest accepted frame size in bytes; FCS bytes, if any, are already in the buffer.
- Clk  in  1  system clock; all state changes on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Tx_ValidFrame  in  1  start request; sampled only in IDLE.
- Tx_AbortFrame  in  1  abort request; sampled in START_FLAG, DATA, END_FLAG.
- Tx_FrameSize  in  8  byte count; sampled with Tx_ValidFrame.
- Tx_Data  in  8  buffer read data; valid the cycle after Tx_RdBuff, held until the next Tx_RdBuff.
- Tx_RdBuff  out  1  one-cycle pulse requesting the next byte.
- Tx  out  1  serial line.
- Tx_Busy  out  1  high in any state other than IDLE.
- Tx_Done  out  1  one-cycle pulse after the last end-flag bit.
- Tx_AbortedTrans  out  1  one-cycle pulse after the last abort bit.

## Operation
- Reset values: Tx=1, Tx_RdBuff=0, Tx_Busy=0, Tx_Done=0, Tx_AbortedTrans=0, state=IDLE, all counters 0.
- States and transitions:
  - IDLE: Tx=1. On Tx_ValidFrame with 1 ≤ Tx_FrameSize ≤ MAX_BYTES, go to START_FLAG. Size 0 or > MAX_BYTES is ignored and produces no pulse.
  - START_FLAG: send 8'h7E LSB first (0,1,1,1,1,1,1,0), then go to DATA.
  - DATA: send N bytes LSB first with zero insertion, then go to END_FLAG.
  - END_FLAG: send 8'h7E, pulse Tx_Done, go to IDLE.
  - ABORT: send 8'hFE LSB first (0 followed by seven 1s), pulse Tx_AbortedTrans, go to IDLE.
- Byte fetch:
  - Tx_RdBuff pulses in bit 6 of the start flag, which fetches byte 0.
  - For each byte k < N-1, Tx_RdBuff pulses in the cycle bit 6 of byte k is emitted. It never pulses for a byte beyond N.
  - Exactly N pulses occur per completed frame.
- Zero insertion:
  - A ones counter (0..5) counts consecutive 1 data bits. It continues across byte boundaries and is cleared by any 0 bit and by entry to DATA.
  - When the count reaches 5, the next cycle emits an inserted 0. The pending data bit is stalled one cycle and the counter clears.
  - If the final data bit brings the count to 5, the inserted 0 is sent before the end flag.
  - Flags and abort are never stuffed.
- Abort:
  - Tx_AbortFrame in START_FLAG, DATA or END_FLAG truncates the current bit stream. The next cycle emits the first abort bit (0).
  - Tx_RdBuff is suppressed from that cycle on.
  - Abort in IDLE or ABORT is ignored.
- Simultaneous events:
  - Tx_ValidFrame and Tx_AbortFrame together in IDLE: no frame starts.
  - Tx_AbortFrame in the last end-flag bit: the abort wins, Tx_Done is not pulsed, and Tx_AbortedTrans follows.
- Reset mid-frame: Tx returns to 1 immediately (asynchronous), no pulses are emitted, and the sequencer restarts from IDLE.

## Timing
- Tx_ValidFrame sampled high in cycle t means Tx=0 (first flag bit) in cycle t+1 and Tx_Busy=1 from t+1.
- Frame length in cycles is 16 + 8·N + S, where S is the number of inserted zeros. Tx_Done is high in the cycle after the last flag bit, while Tx_Busy=0 and Tx=1.
- Abort length: Tx_AbortFrame at t gives abort bits in t+1..t+8 and Tx_AbortedTrans=1 at t+9.
- Back-to-back frames: a new Tx_ValidFrame is accepted in the cycle Tx_Done is high. This guarantees at least one idle 1 between frames.
- All outputs are registered.

## Structure
- Shared package hdlc_pkg holds:
  - the state enum (IDLE, START_FLAG, DATA, END_FLAG, ABORT);
  - HDLC_FLAG=8'h7E and HDLC_ABORT=8'hFE;
  - MAX_FRAME_BYTES=126, used as the MAX_BYTES default.
- Sub-module hdlc_zero_insert holds the ones counter and the stall/insert decision. Its ports: bit in, bit valid, clear, stall out, insert out.
- The top level holds the FSM, the 3-bit bit counter, the 8-bit byte counter and the shift register.

## Test plan
- One-byte frame, Tx_Data=8'h00, N=1:
  - Tx reads 01111110 00000000 01111110, 24 cycles total.
  - Exactly one Tx_RdBuff pulse; Tx_Done at cycle 25.
- Frame N=2, bytes 8'hFF, 8'hFF:
  - Zeros are inserted after the 5th and 10th ones, and after the 15th one, before the end flag.
  - Frame is 35 cycles; the receiver-side FlagDetect assertion fires only at the two true flags.
- Frame N=3 with Tx_AbortFrame in the 4th bit of byte 1:
  - Next cycles read 0,1,1,1,1,1,1,1, then Tx_AbortedTrans pulses once.
  - No Tx_Done and no further Tx_RdBuff pulses.
- Tx_FrameSize=0 and separately 127:
  - Tx stays 1, Tx_Busy stays 0, and no pulses occur for 50 cycles.
- Back-to-back frames of N=1 each:
  - The second Tx_ValidFrame is raised in the Tx_Done cycle.
  - The second start flag begins one cycle later with exactly one idle 1 between the frames.
- Rst asserted low in the middle of DATA:
  - Tx=1 and all outputs are at reset values within the same cycle.
  - After release, a fresh N=1 frame transmits correctly.
